// File: rtl/booth_mul_seq.sv
// Radix-4 Booth multiplier sequencer: one partial product per cycle into a 128-bit accumulator.
// Result lands 34 edges after accept (18 for MULW); held until out_ready, abortable by flush.
module booth_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic        flush,
  input  logic        mulw,
  input  logic [1:0]  mul_signed,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result_hi,
  output logic [63:0] result_lo
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, next_state;
  logic [127:0]   xs;
  logic [65:0]    ys;
  logic           y_prev;
  logic [127:0]   acc;
  logic [5:0]     cnt;
  logic [5:0]     n_iter;
  logic           is_w;
  logic           accept;
  logic           last;
  logic [65:0]    x_ext, y_ext;
  logic [2:0]     grp;
  logic [127:0]   pp;

  assign accept = mul_valid && (state == IDLE) && !flush;
  assign last   = (cnt == n_iter);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = BUSY;
      BUSY:    if (last)      next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_comb begin
    mul_ready = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand extension; MULW always treats the low words as signed.
  always_comb begin
    if (mulw) begin
      x_ext = {{34{multiplicand[31]}}, multiplicand[31:0]};
      y_ext = {{34{multiplier[31]}}, multiplier[31:0]};
    end else begin
      x_ext = mul_signed[1] ? {{2{multiplicand[63]}}, multiplicand} : {2'b00, multiplicand};
      y_ext = (mul_signed == 2'b11) ? {{2{multiplier[63]}}, multiplier} : {2'b00, multiplier};
    end
  end

  assign grp = {ys[1], ys[0], y_prev};

  always_comb begin
    case (grp)
      3'b001, 3'b010: pp = xs;
      3'b011:         pp = xs << 1;
      3'b100:         pp = -(xs << 1);
      3'b101, 3'b110: pp = -xs;
      default:        pp = '0;
    endcase
  end

  // xs/ys shift by two per step, so the current group always sits at the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs        <= '0;
      ys        <= '0;
      y_prev    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      n_iter    <= '0;
      is_w      <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (accept) begin
      xs     <= {{62{x_ext[65]}}, x_ext};
      ys     <= y_ext;
      y_prev <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      n_iter <= mulw ? 6'd17 : 6'd33;
      is_w   <= mulw;
    end else if (state == BUSY && !flush) begin
      if (!last) begin
        acc    <= acc + pp;
        xs     <= xs << 2;
        ys     <= ys >> 2;
        y_prev <= ys[1];
        cnt    <= cnt + 6'd1;
      end else if (is_w) begin
        result_hi <= '0;
        result_lo <= {{32{acc[31]}}, acc[31:0]};
      end else begin
        result_hi <= acc[127:64];
        result_lo <= acc[63:0];
      end
    end
  end

endmodule
